// File: rtl/sc_rr_crossbar_slave_port.sv
// Slave-side transaction stage behind the 2-master round-robin arbiter.
// Latches the granted command, runs the slave req/ack handshake with a watchdog, and routes completion back.
//
// state | meaning
// IDLE  | waiting for a one-hot grant
// BUSY  | o_sl_req high, waiting for slave ack, watchdog running
// DONE  | completion sent, waiting for the arbiter to drop its grant
module sc_rr_crossbar_slave_port #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 16
) (
    input  logic          i_clk,
    input  logic          i_resetb,
    input  logic [1:0]    i_ms_en,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    input  logic          i_m1_we,
    output logic          o_sl_req,
    output logic [AW-1:0] o_sl_addr,
    output logic [DW-1:0] o_sl_wdata,
    output logic          o_sl_we,
    input  logic          i_sl_ack,
    input  logic [DW-1:0] i_sl_rdata,
    output logic          o_m0_ack,
    output logic          o_m1_ack,
    output logic          o_m0_err,
    output logic          o_m1_err,
    output logic [DW-1:0] o_ms_rdata,
    output logic          o_arb_ack
);

    localparam int WDW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    localparam logic [WDW-1:0] WD_LIM = WDW'(TO_CYC - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic          m0_err_q, m0_err_d;
    logic          m1_err_q, m1_err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          arb_ack_q, arb_ack_d;

    logic [1:0]    owner_en;
    logic          timeout;

    assign owner_en = owner_q ? 2'b10 : 2'b01;
    assign timeout  = (wd_q == WD_LIM);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wd_d      = wd_q;
        req_d     = req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_err_d  = 1'b0;
        m1_err_d  = 1'b0;
        arb_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_ms_en == 2'b01 || i_ms_en == 2'b10) begin
                    owner_d = i_ms_en[1];
                    addr_d  = i_ms_en[1] ? i_m1_addr  : i_m0_addr;
                    wdata_d = i_ms_en[1] ? i_m1_wdata : i_m0_wdata;
                    we_d    = i_ms_en[1] ? i_m1_we    : i_m0_we;
                    req_d   = 1'b1;
                    wd_d    = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Losing the grant abandons the transfer silently; a late slave ack lands in IDLE and is dropped.
                if (i_ms_en != owner_en) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (i_sl_ack || timeout) begin
                    req_d     = 1'b0;
                    arb_ack_d = 1'b1;
                    m0_ack_d  = ~owner_q;
                    m1_ack_d  = owner_q;
                    m0_err_d  = ~owner_q & ~i_sl_ack;
                    m1_err_d  = owner_q & ~i_sl_ack;
                    rdata_d   = (i_sl_ack && !we_q) ? i_sl_rdata : '0;
                    state_d   = DONE;
                end else if (wd_q != WD_LIM) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE: begin
                // The arbiter still shows the old grant for a cycle after ack; wait for it to clear.
                if (i_ms_en == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            wd_q      <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
            arb_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wd_q      <= wd_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            m0_err_q  <= m0_err_d;
            m1_err_q  <= m1_err_d;
            arb_ack_q <= arb_ack_d;
        end
    end

    assign o_sl_req   = req_q;
    assign o_sl_addr  = addr_q;
    assign o_sl_wdata = wdata_q;
    assign o_sl_we    = we_q;
    assign o_m0_ack   = m0_ack_q;
    assign o_m1_ack   = m1_ack_q;
    assign o_m0_err   = m0_err_q;
    assign o_m1_err   = m1_err_q;
    assign o_ms_rdata = rdata_q;
    assign o_arb_ack  = arb_ack_q;

endmodule

// File: tb/tb_sc_rr_crossbar_slave_port.sv
// Bench for sc_rr_crossbar_slave_port: scenario tasks plus a completion scoreboard.
// Expected completions are queued when a transaction is launched and popped when an ack appears.
module tb_sc_rr_crossbar_slave_port;

    logic        i_clk = 1'b0;
    logic        i_resetb = 1'b0;
    logic [1:0]  i_ms_en = 2'b00;
    logic [31:0] i_m0_addr = '0, i_m0_wdata = '0, i_m1_addr = '0, i_m1_wdata = '0;
    logic        i_m0_we = 1'b0, i_m1_we = 1'b0;
    logic        i_sl_ack = 1'b0;
    logic [31:0] i_sl_rdata = '0;
    logic        o_sl_req, o_sl_we, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_arb_ack;
    logic [31:0] o_sl_addr, o_sl_wdata, o_ms_rdata;

    sc_rr_crossbar_slave_port #(.AW(32), .DW(32), .TO_CYC(4)) dut (
        .i_clk(i_clk), .i_resetb(i_resetb), .i_ms_en(i_ms_en),
        .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata), .i_m0_we(i_m0_we),
        .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata), .i_m1_we(i_m1_we),
        .o_sl_req(o_sl_req), .o_sl_addr(o_sl_addr), .o_sl_wdata(o_sl_wdata), .o_sl_we(o_sl_we),
        .i_sl_ack(i_sl_ack), .i_sl_rdata(i_sl_rdata),
        .o_m0_ack(o_m0_ack), .o_m1_ack(o_m1_ack), .o_m0_err(o_m0_err), .o_m1_err(o_m1_err),
        .o_ms_rdata(o_ms_rdata), .o_arb_ack(o_arb_ack)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          owner;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_launch = 0;
    bit   req_prev = 1'b0;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_push(input bit owner, input bit err, input logic [31:0] rdata);
        exp_t e;
        e.owner = owner;
        e.err   = err;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Completion monitor: every ack pulse must match the oldest queued expectation.
    always @(negedge i_clk) begin
        if (i_resetb) begin
            if (o_sl_req && !req_prev) n_launch++;
            req_prev = o_sl_req;
            if (o_m0_ack || o_m1_ack || o_arb_ack) begin
                n_cmp++;
                if (o_arb_ack !== (o_m0_ack | o_m1_ack) || (o_m0_ack && o_m1_ack)) begin
                    n_bad++;
                    $display("FAIL ack_coherence: m0=%b m1=%b arb=%b required arb==m0|m1 and not both", o_m0_ack, o_m1_ack, o_arb_ack);
                end
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_ack at %0t: m0=%b m1=%b required no ack", $time, o_m0_ack, o_m1_ack);
                end else begin
                    exp_t e;
                    logic got_err;
                    e = sb.pop_front();
                    got_err = o_m1_ack ? o_m1_err : o_m0_err;
                    if (o_m1_ack !== e.owner || got_err !== e.err || o_ms_rdata !== e.rdata) begin
                        n_bad++;
                        $display("FAIL completion: owner=%b err=%b rdata=%h required owner=%b err=%b rdata=%h",
                                 o_m1_ack, got_err, o_ms_rdata, e.owner, e.err, e.rdata);
                    end
                end
            end
        end else begin
            req_prev = 1'b0;
        end
    end

    task automatic test_reset();
        i_resetb = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({o_sl_req, o_sl_we, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_arb_ack} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 0000000", {o_sl_req, o_sl_we, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_arb_ack});
        end
        n_cmp++;
        if (o_sl_addr !== 32'h0 || o_sl_wdata !== 32'h0 || o_ms_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0", o_sl_addr, o_sl_wdata, o_ms_rdata);
        end
        i_resetb = 1'b1;
        tick();
    endtask

    task automatic test_m0_read();
        i_m0_addr = 32'h100; i_m0_we = 1'b0; i_m0_wdata = 32'h0;
        i_ms_en = 2'b01;
        expect_push(1'b0, 1'b0, 32'hCAFE0001);
        tick();
        n_cmp++;
        if (o_sl_req !== 1'b1 || o_sl_addr !== 32'h100 || o_sl_we !== 1'b0) begin
            n_bad++;
            $display("FAIL m0_read_launch: req=%b addr=%h we=%b required 1/100/0", o_sl_req, o_sl_addr, o_sl_we);
        end
        tick();
        tick();
        i_sl_ack = 1'b1; i_sl_rdata = 32'hCAFE0001;
        tick();
        i_sl_ack = 1'b0; i_sl_rdata = 32'h0BAD0BAD;
        n_cmp++;
        if (o_m0_ack !== 1'b1 || o_m1_ack !== 1'b0 || o_sl_req !== 1'b0 || o_ms_rdata !== 32'hCAFE0001) begin
            n_bad++;
            $display("FAIL m0_read_done: m0_ack=%b m1_ack=%b req=%b rdata=%h required 1/0/0/cafe0001", o_m0_ack, o_m1_ack, o_sl_req, o_ms_rdata);
        end
        i_ms_en = 2'b00;
        tick();
        n_cmp++;
        if (o_m0_ack !== 1'b0 || o_arb_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL m0_read_pulse: m0_ack=%b arb_ack=%b required 0/0", o_m0_ack, o_arb_ack);
        end
        tick();
    endtask

    task automatic test_watchdog();
        int  cnt = 0;
        bit  seen = 1'b0;
        i_m0_addr = 32'h180; i_m0_we = 1'b0;
        i_ms_en = 2'b01;
        expect_push(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_m0_ack) begin
                seen = 1'b1;
                break;
            end
            if (o_sl_req) cnt++;
        end
        n_cmp++;
        if (!seen || cnt != 4) begin
            n_bad++;
            $display("FAIL watchdog_len: seen=%b req_cycles=%0d required seen=1 req_cycles=4", seen, cnt);
        end
        n_cmp++;
        if (o_m0_err !== 1'b1 || o_ms_rdata !== 32'h0 || o_arb_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL watchdog_err: err=%b rdata=%h arb=%b required 1/0/1", o_m0_err, o_ms_rdata, o_arb_ack);
        end
        i_ms_en = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_m1_write();
        i_m1_addr = 32'h204; i_m1_wdata = 32'h55AA55AA; i_m1_we = 1'b1;
        i_ms_en = 2'b10;
        expect_push(1'b1, 1'b0, 32'h0);
        tick();
        i_m1_addr = 32'hFFF0; i_m1_wdata = 32'h12121212; i_m1_we = 1'b0;
        i_m0_addr = 32'h9990; i_m0_wdata = 32'h34343434; i_m0_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_sl_req !== 1'b1 || o_sl_addr !== 32'h204 || o_sl_wdata !== 32'h55AA55AA || o_sl_we !== 1'b1) begin
                n_bad++;
                $display("FAIL m1_write_hold[%0d]: req=%b addr=%h wdata=%h we=%b required 1/204/55aa55aa/1", i, o_sl_req, o_sl_addr, o_sl_wdata, o_sl_we);
            end
            if (i < 2) tick();
        end
        i_sl_ack = 1'b1; i_sl_rdata = 32'hDEADBEEF;
        tick();
        i_sl_ack = 1'b0;
        n_cmp++;
        if (o_m1_ack !== 1'b1 || o_m0_ack !== 1'b0 || o_ms_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL m1_write_done: m1_ack=%b m0_ack=%b rdata=%h required 1/0/0", o_m1_ack, o_m0_ack, o_ms_rdata);
        end
        i_ms_en = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_ack_wins();
        i_m1_addr = 32'h300; i_m1_we = 1'b0;
        i_ms_en = 2'b10;
        expect_push(1'b1, 1'b0, 32'h12345678);
        tick();
        tick();
        tick();
        tick();
        i_sl_ack = 1'b1; i_sl_rdata = 32'h12345678;
        tick();
        i_sl_ack = 1'b0;
        n_cmp++;
        if (o_m1_ack !== 1'b1 || o_m1_err !== 1'b0 || o_ms_rdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL ack_wins: ack=%b err=%b rdata=%h required 1/0/12345678", o_m1_ack, o_m1_err, o_ms_rdata);
        end
        i_ms_en = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_abort();
        i_m1_addr = 32'h400; i_m1_we = 1'b0;
        i_ms_en = 2'b10;
        tick();
        tick();
        tick();
        i_ms_en = 2'b00;
        tick();
        n_cmp++;
        if (o_sl_req !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_req: req=%b required 0", o_sl_req);
        end
        i_sl_ack = 1'b1; i_sl_rdata = 32'h77777777;
        tick();
        i_sl_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0 || o_arb_ack !== 1'b0 || o_sl_req !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_quiet[%0d]: m0=%b m1=%b arb=%b req=%b required all 0", i, o_m0_ack, o_m1_ack, o_arb_ack, o_sl_req);
            end
            tick();
        end
    endtask

    task automatic test_stale_grant();
        int base;
        base = n_launch;
        i_m0_addr = 32'h40; i_m0_we = 1'b0;
        i_ms_en = 2'b01;
        expect_push(1'b0, 1'b0, 32'h0000A5A5);
        tick();
        tick();
        i_sl_ack = 1'b1; i_sl_rdata = 32'h0000A5A5;
        tick();
        i_sl_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) i_ms_en = 2'b00;
            tick();
            n_cmp++;
            if (o_sl_req !== 1'b0) begin
                n_bad++;
                $display("FAIL stale_no_relaunch[%0d]: req=%b required 0", i, o_sl_req);
            end
        end
        i_m1_addr = 32'h80; i_m1_we = 1'b0;
        i_ms_en = 2'b10;
        expect_push(1'b1, 1'b0, 32'h00005A5A);
        tick();
        n_cmp++;
        if (o_sl_req !== 1'b1 || o_sl_addr !== 32'h80) begin
            n_bad++;
            $display("FAIL stale_m1_launch: req=%b addr=%h required 1/80", o_sl_req, o_sl_addr);
        end
        i_sl_ack = 1'b1; i_sl_rdata = 32'h00005A5A;
        tick();
        i_sl_ack = 1'b0;
        i_ms_en = 2'b00;
        tick();
        tick();
        n_cmp++;
        if (n_launch - base != 2) begin
            n_bad++;
            $display("FAIL stale_launch_count: got %0d required 2", n_launch - base);
        end
    endtask

    task automatic test_reset_busy();
        i_m0_addr = 32'h10; i_m0_wdata = 32'h99; i_m0_we = 1'b1;
        i_ms_en = 2'b01;
        tick();
        n_cmp++;
        if (o_sl_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_busy_launch: req=%b required 1", o_sl_req);
        end
        #2 i_resetb = 1'b0;
        #1;
        n_cmp++;
        if ({o_sl_req, o_sl_we, o_m0_ack, o_m1_ack, o_arb_ack} !== 5'b0 || o_sl_addr !== 32'h0 ||
            o_sl_wdata !== 32'h0 || o_ms_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_busy_async: ctrl=%b addr=%h wdata=%h rdata=%h required all 0",
                     {o_sl_req, o_sl_we, o_m0_ack, o_m1_ack, o_arb_ack}, o_sl_addr, o_sl_wdata, o_ms_rdata);
        end
        i_ms_en = 2'b00;
        tick();
        tick();
        i_resetb = 1'b1;
        i_sl_ack = 1'b1;
        tick();
        i_sl_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o_sl_req !== 1'b0 || o_m0_ack !== 1'b0 || o_arb_ack !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_busy_after[%0d]: req=%b m0=%b arb=%b required 0/0/0", i, o_sl_req, o_m0_ack, o_arb_ack);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_watchdog();
        test_m1_write();
        test_ack_wins();
        test_abort();
        test_stale_grant();
        test_reset_busy();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d completions outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sc_rr_crossbar_slave_port.md
Name: sc_rr_crossbar_slave_port

Overview:
- Slave-side datapath and transaction stage directly downstream of the 2-master round-robin arbiter atom.
- Consumes the arbiter's one-hot master-enable vector and latches the granted master's command. Drives it to the slave with a req/ack handshake.
- Routes the slave's ack/read data back to the owning master and returns a termination ack to the arbiter.
- Adds a watchdog that ends a transaction with an error if the slave never acks.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TO_CYC, 16, watchdog limit in cycles of o_sl_req high without ack (minimum 2).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_resetb  in  1  asynchronous active-low reset.
- i_ms_en  in  2  one-hot grant from the arbiter: bit0 = master 0, bit1 = master 1.
- i_m0_addr  in  AW  master 0 address.
- i_m0_wdata  in  DW  master 0 write data.
- i_m0_we  in  1  master 0 write enable (1 = write).
- i_m1_addr  in  AW  master 1 address.
- i_m1_wdata  in  DW  master 1 write data.
- i_m1_we  in  1  master 1 write enable.
- o_sl_req  out  1  command valid to slave.
- o_sl_addr  out  AW  registered address.
- o_sl_wdata  out  DW  registered write data.
- o_sl_we  out  1  registered write enable.
- i_sl_ack  in  1  slave completion, single-cycle pulse.
- i_sl_rdata  in  DW  slave read data, valid with i_sl_ack.
- o_m0_ack  out  1  completion pulse to master 0.
- o_m1_ack  out  1  completion pulse to master 1.
- o_m0_err  out  1  error qualifier, valid with o_m0_ack.
- o_m1_err  out  1  error qualifier, valid with o_m1_ack.
- o_ms_rdata  out  DW  registered read data; shared bus, qualified by o_mX_ack.
- o_arb_ack  out  1  termination pulse to the arbiter's slave-ack input.

Behaviour:
- Reset (async assert, sync release): state=IDLE, owner=0, watchdog=0. All outputs 0, including o_sl_addr, o_sl_wdata and o_ms_rdata.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - i_ms_en==01 or 10 at edge N: latch that master's addr/wdata/we into o_sl_*, record owner, set o_sl_req=1, clear watchdog, go BUSY. o_sl_req is high from cycle N+1.
  - i_ms_en==00 or 11 (11 is illegal): no action, stay IDLE.
  - i_sl_ack in IDLE is ignored.
- BUSY:
  - o_sl_addr, o_sl_wdata, o_sl_we held stable; master inputs are not re-sampled.
  - Watchdog increments every cycle in BUSY, saturating.
  - i_sl_ack at edge M: o_sl_req=0. o_ms_rdata<=i_sl_rdata when o_sl_we==0, else o_ms_rdata<=0. o_owner_ack=1, o_owner_err=0, o_arb_ack=1 (all one-cycle pulses in cycle M+1). Go DONE.
  - Watchdog reaches TO_CYC-1 with no ack: same as ack path but o_ms_rdata=0 and o_owner_err=1. Go DONE.
  - Ack and watchdog expiry in the same cycle: ack wins, err=0.
  - Abort: i_ms_en no longer equals the recorded owner bit (00, other master, or 11). o_sl_req=0, no master ack, no o_arb_ack, go IDLE. A late i_sl_ack after abort is ignored.
- DONE:
  - Ack pulses deassert after one cycle.
  - Stay until i_ms_en==00 has been sampled, then go IDLE. This prevents relaunching on the stale grant that the arbiter holds one cycle after ack.
  - i_sl_ack in DONE is ignored.
- Latencies:
  - Grant-to-req: 1 cycle.
  - Slave ack to master ack: 1 cycle.
  - Minimum back-to-back transaction spacing: slave ack M → arbiter clears grant M+2 → new grant sampled no earlier than M+3.
- At most one of o_m0_ack/o_m1_ack is high in any cycle. o_arb_ack is high exactly when one of them is high.
- Reset asserted mid-transaction: immediate return to reset values; no ack generated.

Test Plan:
- Master 0 read: i_ms_en=01 with i_m0_addr=0x100, we=0; slave acks 3 cycles after o_sl_req with rdata=0xCAFE0001 → o_sl_addr=0x100 one cycle after grant. One cycle after slave ack: o_m0_ack=1, o_ms_rdata=0xCAFE0001, o_m0_err=0, o_arb_ack=1. o_m1_ack stays 0.
- Master 1 write: i_ms_en=10, addr=0x204, wdata=0x55AA55AA, we=1; master 1 inputs change while BUSY → o_sl_* remain 0x204/0x55AA55AA/1 until ack. o_m1_ack pulses once with o_ms_rdata=0.
- Watchdog with TO_CYC=4: grant 01, slave silent → o_sl_req high exactly 4 cycles, then o_m0_ack=1, o_m0_err=1, o_arb_ack=1, o_ms_rdata=0.
- Abort: grant 10, i_ms_en drops to 00 after 2 cycles in BUSY, slave acks 1 cycle later → o_sl_req drops; no o_m1_ack, no o_arb_ack; FSM in IDLE.
- Stale grant: after an ack, i_ms_en held 01 for 2 more cycles, then 00, then 10 → exactly one transaction for master 0 and exactly one new transaction for master 1, started one cycle after 10 is sampled.
- Reset while BUSY: deassert i_resetb mid-transaction → all outputs 0 asynchronously; after release, IDLE with no spurious ack.
